// File: rtl/ahb_sdram_responder.sv
// AHB-style SDRAM stand-in: word memory, fixed wait-states, refresh stalls.
// Ports: HCLK, HRESETn (sync, active-low), HSEL, HWRITE, HADDR, HWDATA in;
//        HREADY, HRDATA, HRESP out.
// Optional: define AHB_SDRAM_ADDR_CHECK_EN to flag out-of-range addresses
//           with HRESP; otherwise upper address bits alias.
module ahb_sdram_responder #(
    parameter int DEPTH          = 256,
    parameter int WAIT_CYCLES    = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (WAIT_CYCLES > REFRESH_CYCLES) ?
                          WAIT_CYCLES : REFRESH_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int RW   = $clog2(REFRESH_PERIOD);

    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_SET  = RW'(REFRESH_PERIOD - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_REFRESH
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  wcnt;
    logic [RW-1:0]  rcnt;
    logic           ref_pending;

    logic           lat_write;
    logic [AW-1:0]  lat_idx;
    logic [31:0]    lat_data;
    logic           lat_err;

    logic [31:0]    mem [DEPTH];

    logic [AW-1:0]  in_idx;
    logic           in_err;
    logic           accept;
    logic           go_done;
    logic           c_write;
    logic [AW-1:0]  c_idx;
    logic [31:0]    c_data;
    logic           c_err;

    assign in_idx = HADDR[AW+1:2];

`ifdef AHB_SDRAM_ADDR_CHECK_EN
    assign in_err = |HADDR[31:AW+2];
    logic unused_lo;
    assign unused_lo = ^HADDR[1:0];
`else
    assign in_err = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{HADDR[31:AW+2], HADDR[1:0]};
`endif

    assign accept = (state == S_IDLE) && !ref_pending && HSEL;

    // With zero wait-states (or an error) DONE is entered on the accept
    // edge itself, so the commit must use the live bus inputs.
    assign c_write = accept ? HWRITE : lat_write;
    assign c_idx   = accept ? in_idx : lat_idx;
    assign c_data  = accept ? HWDATA : lat_data;
    assign c_err   = accept ? in_err : lat_err;
    assign go_done = (state_n == S_DONE);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (ref_pending)
                    state_n = S_REFRESH;
                else if (HSEL)
                    state_n = (WAIT_CYCLES == 0 || in_err) ?
                              S_DONE : S_WAIT;
            end
            S_WAIT:    if (wcnt == WAIT_LAST) state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            S_REFRESH: if (wcnt == REF_LAST) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        HREADY = 1'b0;
        unique case (1'b1)
            state == S_IDLE: HREADY = !ref_pending;
            state == S_DONE: HREADY = 1'b1;
            default:         HREADY = 1'b0;
        endcase
    end

    // Shared stall counter for WAIT and REFRESH; restarts on every change.
    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            wcnt <= '0;
        else if (state_n == state &&
                 (state == S_WAIT || state == S_REFRESH))
            wcnt <= wcnt + 1'b1;
        else
            wcnt <= '0;
    end

    // Clearing on REFRESH entry wins over a coincident new request,
    // so a request landing on an already-pending one is absorbed.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rcnt        <= '0;
            ref_pending <= 1'b0;
        end else begin
            rcnt <= (rcnt == RCNT_LAST) ? '0 : rcnt + 1'b1;
            if (state == S_IDLE && ref_pending)
                ref_pending <= 1'b0;
            else if (rcnt == RCNT_SET)
                ref_pending <= 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            lat_write <= HWRITE;
            lat_idx   <= in_idx;
            lat_data  <= HWDATA;
            lat_err   <= in_err;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && go_done && c_write && !c_err)
            mem[c_idx] <= c_data;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            HRDATA <= '0;
        else if (go_done && !c_write && !c_err)
            HRDATA <= mem[c_idx];
    end

`ifdef AHB_SDRAM_ADDR_CHECK_EN
    always_ff @(posedge HCLK) begin
        if (!HRESETn) HRESP <= 1'b0;
        else          HRESP <= go_done && c_err;
    end
`else
    assign HRESP = 1'b0;
`endif

endmodule
